// File: rtl/crossbar_pkg.sv
// Shared constants and helpers for the two-input, two-output crossbar router.
package crossbar_pkg;

    localparam logic PORT_C     = 1'b0;
    localparam logic PORT_D     = 1'b1;
    localparam int   CONFLICT_W = 8;

    function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] value);
        if (value == {CONFLICT_W{1'b1}}) begin
            return value;
        end else begin
            return value + CONFLICT_W'(1);
        end
    endfunction

endpackage

// File: rtl/crossbar_router_if.sv
// Bundle of every handshake, payload and status signal of the crossbar router.
interface crossbar_router_if #(parameter int data_width = 8);
    import crossbar_pkg::*;

    logic                  in_a_valid;
    logic                  in_a_dest;
    logic [data_width-1:0] in_a_data;
    logic                  in_a_ready;
    logic                  in_b_valid;
    logic                  in_b_dest;
    logic [data_width-1:0] in_b_data;
    logic                  in_b_ready;
    logic                  out_c_valid;
    logic [data_width-1:0] out_c_data;
    logic                  out_c_ready;
    logic                  out_d_valid;
    logic [data_width-1:0] out_d_data;
    logic                  out_d_ready;
    logic                  swap;
    logic [CONFLICT_W-1:0] conflict_count;

    modport slave (
        input  in_a_valid, in_a_dest, in_a_data, in_b_valid, in_b_dest, in_b_data,
        input  out_c_ready, out_d_ready,
        output in_a_ready, in_b_ready, out_c_valid, out_c_data, out_d_valid, out_d_data,
        output swap, conflict_count
    );

    modport master (
        output in_a_valid, in_a_dest, in_a_data, in_b_valid, in_b_dest, in_b_data,
        output out_c_ready, out_d_ready,
        input  in_a_ready, in_b_ready, out_c_valid, out_c_data, out_d_valid, out_d_data,
        input  swap, conflict_count
    );

endinterface

// File: rtl/crossbar_out_slot.sv
// One registered output slot with a two-way round-robin arbiter in front of it.
module crossbar_out_slot #(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic [data_width-1:0] data_a,
    input  logic [data_width-1:0] data_b,
    input  logic                  out_ready,
    output logic                  win_a,
    output logic                  win_b,
    output logic                  conflict,
    output logic                  out_valid,
    output logic [data_width-1:0] out_data
);

    logic                  ptr_r;
    logic                  valid_r;
    logic [data_width-1:0] data_r;
    logic                  loadable_s;
    logic                  contend_s;
    logic                  grant_a_s;
    logic                  grant_b_s;

    // Arbitration: the pointer only matters when both inputs want this slot.
    always_comb begin
        loadable_s = ~valid_r | out_ready;
        contend_s  = req_a & req_b;
        win_a      = loadable_s & (~contend_s | ~ptr_r);
        win_b      = loadable_s & (~contend_s | ptr_r);
        grant_a_s  = req_a & win_a;
        grant_b_s  = req_b & win_b;
        conflict   = contend_s & loadable_s;
    end

    // Held word: a new load takes priority over a plain drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (grant_a_s) begin
            valid_r <= 1'b1;
            data_r  <= data_a;
        end else if (grant_b_s) begin
            valid_r <= 1'b1;
            data_r  <= data_b;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    // Round-robin pointer flips only on a contended grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (conflict) begin
            ptr_r <= ~ptr_r;
        end
    end

    assign out_valid = valid_r;
    assign out_data  = data_r;

endmodule

// File: rtl/crossbar_router.sv
// 2x2 crossbar: inputs a/b routed by a 1-bit destination to registered outputs c/d.
module crossbar_router
    import crossbar_pkg::*;
#(
    parameter int data_width = 8
) (
    input logic              clk,
    input logic              rst,
    crossbar_router_if.slave bus
);

    logic                  req_ac_s, req_ad_s, req_bc_s, req_bd_s;
    logic                  win_ac_s, win_ad_s, win_bc_s, win_bd_s;
    logic                  conflict_c_s, conflict_d_s;
    logic                  ready_a_s, ready_b_s;
    logic                  acc_a_s, acc_b_s;
    logic                  swap_r;
    logic [CONFLICT_W-1:0] count_r;

    // Request decode and ready selection; readies are forced low throughout reset.
    always_comb begin
        req_ac_s = bus.in_a_valid & (bus.in_a_dest == PORT_C);
        req_ad_s = bus.in_a_valid & (bus.in_a_dest == PORT_D);
        req_bc_s = bus.in_b_valid & (bus.in_b_dest == PORT_C);
        req_bd_s = bus.in_b_valid & (bus.in_b_dest == PORT_D);
        if (rst) begin
            ready_a_s = 1'b0;
            ready_b_s = 1'b0;
        end else begin
            ready_a_s = (bus.in_a_dest == PORT_C) ? win_ac_s : win_ad_s;
            ready_b_s = (bus.in_b_dest == PORT_C) ? win_bc_s : win_bd_s;
        end
        acc_a_s = bus.in_a_valid & ready_a_s;
        acc_b_s = bus.in_b_valid & ready_b_s;
    end

    crossbar_out_slot #(.data_width(data_width)) u_slot_c (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_ac_s),
        .req_b     (req_bc_s),
        .data_a    (bus.in_a_data),
        .data_b    (bus.in_b_data),
        .out_ready (bus.out_c_ready),
        .win_a     (win_ac_s),
        .win_b     (win_bc_s),
        .conflict  (conflict_c_s),
        .out_valid (bus.out_c_valid),
        .out_data  (bus.out_c_data)
    );

    crossbar_out_slot #(.data_width(data_width)) u_slot_d (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_ad_s),
        .req_b     (req_bd_s),
        .data_a    (bus.in_a_data),
        .data_b    (bus.in_b_data),
        .out_ready (bus.out_d_ready),
        .win_a     (win_ad_s),
        .win_b     (win_bd_s),
        .conflict  (conflict_d_s),
        .out_valid (bus.out_d_valid),
        .out_data  (bus.out_d_data)
    );

    // Swap flag remembers whether the latest transferring cycle carried a crossed route.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_r <= 1'b0;
        end else if (acc_a_s | acc_b_s) begin
            swap_r <= (acc_a_s & (bus.in_a_dest == PORT_D)) | (acc_b_s & (bus.in_b_dest == PORT_C));
        end
    end

    // Contention can occur at only one output per cycle, so one increment suffices.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= '0;
        end else if (conflict_c_s | conflict_d_s) begin
            count_r <= sat_inc(count_r);
        end
    end

    assign bus.in_a_ready     = ready_a_s;
    assign bus.in_b_ready     = ready_b_s;
    assign bus.swap           = swap_r;
    assign bus.conflict_count = count_r;

endmodule

// File: tb/tb_crossbar_router.sv
// Self-checking bench for crossbar_router: directed scenarios plus random traffic against a slot-array model.
module tb_crossbar_router;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    crossbar_router_if #(.data_width(8)) bus();

    crossbar_router #(.data_width(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: one entry per output port, indexed by destination.
    bit         m_valid[2];
    logic [7:0] m_data[2];
    bit         m_ptr[2];
    int         m_count;
    bit         m_swap;

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = 8'h00;
            m_ptr[i]   = 1'b0;
        end
        m_count = 0;
        m_swap  = 1'b0;
    endtask

    task automatic drive(input bit av, input bit ad, input logic [7:0] adat,
                         input bit bv, input bit bd, input logic [7:0] bdat,
                         input bit cr, input bit dr);
        bus.in_a_valid  = av;
        bus.in_a_dest   = ad;
        bus.in_a_data   = adat;
        bus.in_b_valid  = bv;
        bus.in_b_dest   = bd;
        bus.in_b_data   = bdat;
        bus.out_c_ready = cr;
        bus.out_d_ready = dr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: predict readies, sample the DUT's readies, then advance the model across the edge.
    task automatic cycle(output bit ara, output bit arb, output bit era, output bit erb);
        bit         av, ad, bv, bd, cr, dr, contend;
        bit         load[2];
        logic [7:0] adat, bdat;
        #1;
        av = bus.in_a_valid;  ad = bus.in_a_dest;  adat = bus.in_a_data;
        bv = bus.in_b_valid;  bd = bus.in_b_dest;  bdat = bus.in_b_data;
        cr = bus.out_c_ready; dr = bus.out_d_ready;
        load[0] = !m_valid[0] || cr;
        load[1] = !m_valid[1] || dr;
        contend = av && bv && (ad == bd);
        era = load[ad] && !(contend && m_ptr[ad]);
        erb = load[bd] && !(contend && !m_ptr[bd]);
        ara = bus.in_a_ready;
        arb = bus.in_b_ready;
        @(posedge clk);
        if (m_valid[0] && cr) m_valid[0] = 1'b0;
        if (m_valid[1] && dr) m_valid[1] = 1'b0;
        if (av && era) begin m_valid[ad] = 1'b1; m_data[ad] = adat; end
        if (bv && erb) begin m_valid[bd] = 1'b1; m_data[bd] = bdat; end
        if (contend && load[ad]) begin
            m_ptr[ad] = !m_ptr[ad];
            if (m_count < 255) m_count++;
        end
        if ((av && era) || (bv && erb))
            m_swap = (av && era && ad) || (bv && erb && !bd);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'hAA, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        total++; if (bus.in_a_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_a got=%0b want=0", bus.in_a_ready); end
        total++; if (bus.in_b_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_b got=%0b want=0", bus.in_b_ready); end
        total++; if (bus.out_c_valid !== 1'b0) begin bad++; $display("FAIL reset_c_valid got=%0b want=0", bus.out_c_valid); end
        total++; if (bus.out_d_valid !== 1'b0) begin bad++; $display("FAIL reset_d_valid got=%0b want=0", bus.out_d_valid); end
        total++; if (bus.out_c_data !== 8'h00) begin bad++; $display("FAIL reset_c_data got=%0h want=0", bus.out_c_data); end
        total++; if (bus.out_d_data !== 8'h00) begin bad++; $display("FAIL reset_d_data got=%0h want=0", bus.out_d_data); end
        total++; if (bus.swap !== 1'b0) begin bad++; $display("FAIL reset_swap got=%0b want=0", bus.swap); end
        total++; if (bus.conflict_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.conflict_count); end
    endtask

    task automatic test_straight_and_crossed();
        bit ara, arb, era, erb;
        do_reset();
        drive(1'b1, 1'b0, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if ({ara, arb} !== 2'b11) begin bad++; $display("FAIL straight_ready got=%b want=11", {ara, arb}); end
        total++; if ({bus.out_c_valid, bus.out_c_data} !== {1'b1, 8'h11}) begin bad++; $display("FAIL straight_c got=%0h want=111", {bus.out_c_valid, bus.out_c_data}); end
        total++; if ({bus.out_d_valid, bus.out_d_data} !== {1'b1, 8'h22}) begin bad++; $display("FAIL straight_d got=%0h want=122", {bus.out_d_valid, bus.out_d_data}); end
        total++; if (bus.swap !== 1'b0) begin bad++; $display("FAIL straight_swap got=%0b want=0", bus.swap); end
        drive(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 8'h44, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if ({ara, arb} !== 2'b11) begin bad++; $display("FAIL crossed_ready got=%b want=11", {ara, arb}); end
        total++; if ({bus.out_c_valid, bus.out_c_data} !== {1'b1, 8'h44}) begin bad++; $display("FAIL crossed_c got=%0h want=144", {bus.out_c_valid, bus.out_c_data}); end
        total++; if ({bus.out_d_valid, bus.out_d_data} !== {1'b1, 8'h33}) begin bad++; $display("FAIL crossed_d got=%0h want=133", {bus.out_d_valid, bus.out_d_data}); end
        total++; if (bus.swap !== 1'b1) begin bad++; $display("FAIL crossed_swap got=%0b want=1", bus.swap); end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if (bus.swap !== 1'b1) begin bad++; $display("FAIL idle_swap_hold got=%0b want=1", bus.swap); end
    endtask

    task automatic test_contention();
        bit         ara, arb, era, erb;
        logic [7:0] want;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b1, 1'b0, 8'hB0 + 8'(i), 1'b1, 1'b1);
            cycle(ara, arb, era, erb);
            want = (i % 2 == 0) ? 8'hA0 + 8'(i) : 8'hB0 + 8'(i);
            total++; if ({ara, arb} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL contention_grant[%0d] got=%b", i, {ara, arb}); end
            total++; if (bus.out_c_data !== want) begin bad++; $display("FAIL contention_data[%0d] got=%0h want=%0h", i, bus.out_c_data, want); end
        end
        total++; if (bus.conflict_count !== 8'd4) begin bad++; $display("FAIL contention_count got=%0d want=4", bus.conflict_count); end
    endtask

    task automatic test_backpressure();
        bit ara, arb, era, erb;
        do_reset();
        drive(1'b1, 1'b1, 8'h66, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(ara, arb, era, erb);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            cycle(ara, arb, era, erb);
            total++; if (ara !== 1'b0) begin bad++; $display("FAIL backpressure_ready[%0d] got=%0b want=0", i, ara); end
            total++; if ({bus.out_d_valid, bus.out_d_data} !== {1'b1, 8'h66}) begin bad++; $display("FAIL backpressure_hold[%0d] got=%0h want=166", i, {bus.out_d_valid, bus.out_d_data}); end
        end
        drive(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if (ara !== 1'b1) begin bad++; $display("FAIL release_ready got=%0b want=1", ara); end
        total++; if ({bus.out_d_valid, bus.out_d_data} !== {1'b1, 8'h77}) begin bad++; $display("FAIL release_load got=%0h want=177", {bus.out_d_valid, bus.out_d_data}); end
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if (bus.out_d_valid !== 1'b0) begin bad++; $display("FAIL drain_d_valid got=%0b want=0", bus.out_d_valid); end
    endtask

    task automatic test_saturation();
        bit ara, arb, era, erb;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b0, 8'(i), 1'b1, 1'b0, 8'(i + 1), 1'b1, 1'b1);
            cycle(ara, arb, era, erb);
            if (i == 254) begin
                total++; if (bus.conflict_count !== 8'd255) begin bad++; $display("FAIL saturation_reach got=%0d want=255", bus.conflict_count); end
            end
        end
        total++; if (bus.conflict_count !== 8'd255) begin bad++; $display("FAIL saturation_hold got=%0d want=255", bus.conflict_count); end
    endtask

    task automatic test_reset_mid();
        bit ara, arb, era, erb;
        do_reset();
        drive(1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 8'h82, 1'b0, 1'b0);
        cycle(ara, arb, era, erb);
        total++; if ({bus.out_c_valid, bus.out_d_valid} !== 2'b11) begin bad++; $display("FAIL midreset_full got=%b want=11", {bus.out_c_valid, bus.out_d_valid}); end
        #2 rst = 1'b1;
        #1;
        total++; if ({bus.out_c_valid, bus.out_d_valid} !== 2'b00) begin bad++; $display("FAIL midreset_valid got=%b want=00", {bus.out_c_valid, bus.out_d_valid}); end
        total++; if ({bus.in_a_ready, bus.in_b_ready} !== 2'b00) begin bad++; $display("FAIL midreset_ready got=%b want=00", {bus.in_a_ready, bus.in_b_ready}); end
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        drive(1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if (ara !== 1'b1) begin bad++; $display("FAIL postreset_ready got=%0b want=1", ara); end
        total++; if ({bus.out_c_valid, bus.out_c_data} !== {1'b1, 8'h55}) begin bad++; $display("FAIL postreset_c got=%0h want=155", {bus.out_c_valid, bus.out_c_data}); end
        drive(1'b1, 1'b1, 8'h5A, 1'b1, 1'b1, 8'h5B, 1'b1, 1'b1);
        cycle(ara, arb, era, erb);
        total++; if ({ara, arb} !== 2'b10) begin bad++; $display("FAIL postreset_ptr got=%b want=10", {ara, arb}); end
    endtask

    task automatic test_random();
        bit ara, arb, era, erb;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 8'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            cycle(ara, arb, era, erb);
            total++; if ({ara, arb} !== {era, erb}) begin bad++; $display("FAIL rand_ready[%0d] got=%b want=%b", i, {ara, arb}, {era, erb}); end
            total++; if ({bus.out_c_valid, bus.out_c_data} !== {m_valid[0], m_data[0]}) begin bad++; $display("FAIL rand_c[%0d] got=%0h want=%0h", i, {bus.out_c_valid, bus.out_c_data}, {m_valid[0], m_data[0]}); end
            total++; if ({bus.out_d_valid, bus.out_d_data} !== {m_valid[1], m_data[1]}) begin bad++; $display("FAIL rand_d[%0d] got=%0h want=%0h", i, {bus.out_d_valid, bus.out_d_data}, {m_valid[1], m_data[1]}); end
            total++; if (bus.swap !== m_swap) begin bad++; $display("FAIL rand_swap[%0d] got=%0b want=%0b", i, bus.swap, m_swap); end
            total++; if (int'(bus.conflict_count) != m_count) begin bad++; $display("FAIL rand_count[%0d] got=%0d want=%0d", i, bus.conflict_count, m_count); end
        end
    endtask

    initial begin
        test_reset();
        test_straight_and_crossed();
        test_contention();
        test_backpressure();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
